// File: rtl/lab2_encoder_4x2_rr.sv
// Registered 4-to-2 encoder with valid/ready output handshake.
// Selection is fixed priority (highest index) or round-robin starting after the last accepted index.
module lab2_encoder_4x2_rr #(
  parameter bit ROUND_ROBIN = 1'b1,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [3:0]       Din,
  input  logic             ready,
  output logic [1:0]       Aout,
  output logic             valid,
  output logic             multi,
  output logic [CNT_W-1:0] enc_count
);

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

  state_t           state_reg, state_next;
  logic [1:0]       aout_reg, aout_next;
  logic [1:0]       last_reg, last_next;
  logic             multi_reg, multi_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;

  logic       sample;
  logic       handshake;
  logic       load;
  logic [1:0] scan_base;
  logic [1:0] sel_idx;
  logic [2:0] ones;
  logic [1:0] cand_idx [4];
  logic [3:0] cand_hit;

  assign sample    = enable & (|Din);
  assign handshake = (state_reg == HOLD) & ready;
  // A back-to-back load must scan from the index being accepted this cycle.
  assign scan_base = handshake ? aout_reg : last_reg;
  assign ones      = {2'b00, Din[0]} + {2'b00, Din[1]} + {2'b00, Din[2]} + {2'b00, Din[3]};

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_scan
      assign cand_idx[gi] = scan_base + 2'(gi + 1);
      assign cand_hit[gi] = Din[cand_idx[gi]];
    end
  endgenerate

  always_comb begin
    sel_idx = 2'd0;
    if (ROUND_ROBIN) begin
      for (int k = 3; k >= 0; k--) begin
        if (cand_hit[k]) sel_idx = cand_idx[k];
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (Din[k]) sel_idx = 2'(k);
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    aout_next  = aout_reg;
    multi_next = multi_reg;
    cnt_next   = cnt_reg;
    last_next  = last_reg;
    load       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (sample) begin
          load       = 1'b1;
          state_next = HOLD;
        end
      end
      HOLD: begin
        if (ready) begin
          cnt_next  = cnt_reg + CNT_W'(1);
          last_next = aout_reg;
          if (sample) load = 1'b1;
          else        state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    if (load) begin
      aout_next  = sel_idx;
      multi_next = (ones >= 3'd2);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      aout_reg  <= 2'd0;
      multi_reg <= 1'b0;
      cnt_reg   <= '0;
      last_reg  <= 2'd3;
    end else begin
      state_reg <= state_next;
      aout_reg  <= aout_next;
      multi_reg <= multi_next;
      cnt_reg   <= cnt_next;
      last_reg  <= last_next;
    end
  end

  assign Aout      = aout_reg;
  assign valid     = (state_reg == HOLD);
  assign multi     = multi_reg;
  assign enc_count = cnt_reg;

endmodule
